// File: rtl/if_id_buffer_if.sv
// if_id_buffer_if: Fetch-side word stream and Decode-side packet stream of the IF/ID buffer
interface if_id_buffer_if;
  logic        in_valid;
  logic [15:0] in_word;
  logic [31:0] in_pc;
  logic [31:0] in_next_pc;
  logic        flush;
  logic        decode_stall;
  logic        fetch_stall;
  logic        out_valid;
  logic [15:0] out_instruction;
  logic [15:0] out_immediate;
  logic        out_has_imm;
  logic [31:0] out_pc;
  logic [31:0] out_next_pc;
  modport master (
    output in_valid, in_word, in_pc, in_next_pc, flush, decode_stall,
    input  fetch_stall, out_valid, out_instruction, out_immediate, out_has_imm, out_pc, out_next_pc
  );
  modport slave (
    input  in_valid, in_word, in_pc, in_next_pc, flush, decode_stall,
    output fetch_stall, out_valid, out_instruction, out_immediate, out_has_imm, out_pc, out_next_pc
  );
endinterface

// File: rtl/if_id_buffer.sv
// if_id_buffer: pairs long opcodes with their immediate and queues complete packets for Decode
module if_id_buffer #(
  parameter int DEPTH    = 2,
  parameter int LONG_BIT = 15
) (
  input logic          clk,
  input logic          rst,
  if_id_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  typedef enum logic {OP, IMM} state_t;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        hasImm;
    logic [31:0] pc;
    logic [31:0] nextPc;
  } packet_t;
  packet_t       mem [DEPTH];
  packet_t       pushPkt;
  packet_t       head;
  state_t        state;
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic [15:0]   heldWord;
  logic [31:0]   heldPc;
  logic          outValid;
  logic          fetchStall;
  logic          accept;
  logic          push;
  logic          pop;
  // Handshake decisions; a full FIFO only stalls Fetch when Decode is also stalled
  always_comb begin
    outValid   = count != '0;
    fetchStall = (count == FULL) && bus.decode_stall;
    accept     = bus.in_valid && !fetchStall && !bus.flush;
    push       = accept && (state == IMM || !bus.in_word[LONG_BIT]);
    pop        = outValid && !bus.decode_stall;
    pushPkt    = state == IMM ? {heldWord, bus.in_word, 1'b1, heldPc, bus.in_next_pc}
                              : {bus.in_word, 16'h0, 1'b0, bus.in_pc, bus.in_next_pc};
    head       = outValid ? mem[rdPtr] : '0;
  end
  assign bus.fetch_stall     = fetchStall;
  assign bus.out_valid       = outValid;
  assign bus.out_instruction = head.instr;
  assign bus.out_immediate   = head.imm;
  assign bus.out_has_imm     = head.hasImm;
  assign bus.out_pc          = head.pc;
  assign bus.out_next_pc     = head.nextPc;
  // Packet storage; stale entries are masked by outValid so no reset is needed
  always_ff @(posedge clk)
    if (push) mem[wrPtr] <= pushPkt;
  // Pointers, occupancy and the opcode/immediate assembly state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      state    <= OP;
      heldWord <= '0;
      heldPc   <= '0;
    end else if (bus.flush) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      state    <= OP;
      heldWord <= '0;
      heldPc   <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      if (accept && state == OP && bus.in_word[LONG_BIT]) begin
        state    <= IMM;
        heldWord <= bus.in_word;
        heldPc   <= bus.in_pc;
      end else if (accept) begin
        state <= OP;
      end
    end
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed vector table, mid-cycle reset sequences and a queue-model random run
module tb_if_id_buffer;
  localparam int DEPTH = 2;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  if_id_buffer_if bus();
  if_id_buffer #(.DEPTH(DEPTH), .LONG_BIT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        has;
    logic [31:0] pc;
    logic [31:0] npc;
  } pkt_t;
  typedef struct packed {
    logic        v;
    logic [15:0] w;
    logic [31:0] pc;
    logic        fl;
    logic        st;
    logic [98:0] exp;
  } vec_t;
  vec_t vecs[$];
  int tests = 0;
  int fails = 0;
  function automatic logic [98:0] pk(logic ev, logic [15:0] ei, logic [15:0] em, logic eh,
                                     logic [31:0] ep, logic [31:0] en, logic efs);
    return {ev, ei, em, eh, ep, en, efs};
  endfunction
  function automatic logic [98:0] obs();
    return {bus.out_valid, bus.out_instruction, bus.out_immediate, bus.out_has_imm,
            bus.out_pc, bus.out_next_pc, bus.fetch_stall};
  endfunction
  task automatic addv(logic v, logic [15:0] w, logic [31:0] pc, logic fl, logic st, logic [98:0] e);
    vecs.push_back({v, w, pc, fl, st, e});
  endtask
  task automatic check(string name, logic [98:0] e);
    logic [98:0] a;
    a = obs();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got %h want %h", name, a, e);
    end
  endtask
  task automatic apply(logic v, logic [15:0] w, logic [31:0] pc, logic fl, logic st);
    @(negedge clk);
    bus.in_valid     = v;
    bus.in_word      = w;
    bus.in_pc        = pc;
    bus.in_next_pc   = pc + 32'd1;
    bus.flush        = fl;
    bus.decode_stall = st;
    #1;
  endtask
  task automatic midReset(string name);
    #1 rst = 1'b0;
    #1 check(name, '0);
    #1 rst = 1'b1;
  endtask
  pkt_t        q[$];
  bit          pend;
  logic [15:0] pw;
  logic [31:0] ppc;
  logic        v;
  logic [15:0] w;
  logic [31:0] pc;
  logic        fl;
  logic        st;
  logic        efs;
  logic        acc;
  pkt_t        hd;
  initial begin
    bus.in_valid = 0; bus.in_word = 0; bus.in_pc = 0; bus.in_next_pc = 0;
    bus.flush = 0; bus.decode_stall = 0;
    // pass-through
    addv(1, 16'h0001, 0, 0, 0, '0);
    addv(1, 16'h0002, 1, 0, 0, pk(1, 16'h0001, 0, 0, 0, 1, 0));
    addv(0, 0, 0, 0, 0, pk(1, 16'h0002, 0, 0, 1, 2, 0));
    // two-word instruction
    addv(1, 16'h8005, 4, 0, 0, '0);
    addv(1, 16'h1234, 5, 0, 0, '0);
    addv(0, 0, 0, 0, 0, pk(1, 16'h8005, 16'h1234, 1, 4, 6, 0));
    // full FIFO, back-pressure, simultaneous pop and push
    addv(1, 16'h0010, 10, 0, 1, '0);
    addv(1, 16'h0011, 11, 0, 1, pk(1, 16'h0010, 0, 0, 10, 11, 0));
    addv(1, 16'h0012, 12, 0, 1, pk(1, 16'h0010, 0, 0, 10, 11, 1));
    addv(1, 16'h0012, 12, 0, 1, pk(1, 16'h0010, 0, 0, 10, 11, 1));
    addv(1, 16'h0012, 12, 0, 0, pk(1, 16'h0010, 0, 0, 10, 11, 0));
    addv(0, 0, 0, 0, 1, pk(1, 16'h0011, 0, 0, 11, 12, 1));
    addv(0, 0, 0, 0, 0, pk(1, 16'h0011, 0, 0, 11, 12, 0));
    addv(0, 0, 0, 0, 0, pk(1, 16'h0012, 0, 0, 12, 13, 0));
    addv(0, 0, 0, 0, 0, '0);
    // flush mid-assembly
    addv(1, 16'h8005, 20, 0, 0, '0);
    addv(1, 16'h1234, 21, 1, 0, '0);
    addv(1, 16'h0007, 22, 0, 0, '0);
    addv(0, 0, 0, 0, 0, pk(1, 16'h0007, 0, 0, 22, 23, 0));
    // flush with full FIFO
    addv(1, 16'h0020, 30, 0, 1, '0);
    addv(1, 16'h0021, 31, 0, 1, pk(1, 16'h0020, 0, 0, 30, 31, 0));
    addv(1, 16'h0022, 32, 1, 1, pk(1, 16'h0020, 0, 0, 30, 31, 1));
    addv(0, 0, 0, 0, 1, '0);
    addv(0, 0, 0, 0, 0, '0);
    @(negedge clk); #1;
    check("reset", '0);
    rst = 1'b1;
    foreach (vecs[i]) begin
      apply(vecs[i].v, vecs[i].w, vecs[i].pc, vecs[i].fl, vecs[i].st);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    // asynchronous reset with a full FIFO, then with a half-assembled instruction
    apply(1, 16'h0060, 50, 0, 1); check("ar0", '0);
    apply(1, 16'h0061, 51, 0, 1); check("ar1", pk(1, 16'h0060, 0, 0, 50, 51, 0));
    apply(1, 16'h0062, 52, 0, 1); check("ar2", pk(1, 16'h0060, 0, 0, 50, 51, 1));
    midReset("rst_full");
    apply(1, 16'h8070, 53, 0, 0); check("ar3", pk(1, 16'h0062, 0, 0, 52, 53, 0));
    apply(1, 16'h0071, 54, 0, 1); check("ar4", '0);
    midReset("rst_imm");
    apply(0, 0, 0, 0, 0); check("ar5", pk(1, 16'h0071, 0, 0, 54, 55, 0));
    // randomized run against a packet-queue model
    q.delete(); pend = 0; pw = 0; ppc = 0;
    v = 0; w = 0; pc = 32'd100; acc = 1;
    for (int c = 0; c < 3000; c++) begin
      if (!(v && !acc)) begin
        v = $urandom_range(0, 9) < 7;
        w = 16'($urandom);
      end
      fl = $urandom_range(0, 19) == 0;
      st = $urandom_range(0, 9) < 4;
      apply(v, w, pc, fl, st);
      efs = (q.size() == DEPTH) && st;
      hd = q.size() != 0 ? q[0] : '0;
      check($sformatf("rand%0d", c), {q.size() != 0, hd, efs});
      acc = v && !efs && !fl;
      if (fl) begin
        q.delete();
        pend = 0;
        v = 0;
        pc = 32'($urandom_range(0, 1000));
      end else begin
        if (q.size() != 0 && !st) void'(q.pop_front());
        if (acc) begin
          if (pend) begin
            q.push_back({pw, w, 1'b1, ppc, pc + 32'd1});
            pend = 0;
          end else if (w[15]) begin
            pend = 1; pw = w; ppc = pc;
          end else begin
            q.push_back({w, 16'h0, 1'b0, pc, pc + 32'd1});
          end
          pc = pc + 32'd1;
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
